rr_decode_arbiter: RTL and testbench
====================================

Name: rr_decode_arbiter

Overview:
- Round-robin arbiter that shares one resource among four requesters.
- Grants are issued as a 2-bit encoded winner index and as its decoded one-hot bus, gated by an enable.
- Sits in front of the shared datapath: grant_idx drives the resource's select mux, and grant[3:0] drives the per-requester acknowledge lines.
- Fairness is by rotating priority pointer; an optional hold-timeout preempts a requester that holds the resource too long.

Parameters:
- MAX_HOLD, 8, maximum consecutive GRANT cycles before forced release (timeout feature only); legal range 1..2^CNT_W.
- CNT_W, 4, width of the hold counter.

Ports:
- clk  input  1  single system clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-low reset; 0 clears all state immediately, independent of clk.
- enable  input  1  arbitration enable; 0 forces grant off and blocks new grants.
- req  input  4  request bits; req[m]=1 means requester m wants the resource and holds it high for as long as it uses it.
- grant  output  4  one-hot grant; grant[m]=1 only when grant_valid=1 and grant_idx==m; all zero otherwise.
- grant_idx  output  2  binary index of the current or last winner.
- grant_valid  output  1  1 while in GRANT state.
- preempt  output  1  one-cycle pulse when a grant is forcibly revoked by timeout.

Behaviour:
- Reset values (asynchronous assert on reset=0):
  - state=IDLE, ptr=0, hold_cnt=0.
  - grant=4'b0000, grant_idx=2'b00, grant_valid=0, preempt=0.
- All outputs are registered. grant is the decode of grant_idx ANDed with grant_valid, so grant is never more than one-hot.
- State IDLE:
  - If enable=1 and req!=0 at an edge, pick the first set req bit scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  - On that same edge: grant_idx=winner, grant_valid=1, hold_cnt=0, go GRANT. Latency is 1 cycle from sampled req to grant.
  - Otherwise stay in IDLE with outputs unchanged (grant_valid=0).
- State GRANT:
  - If enable=0 or req[grant_idx]=0 at an edge: grant_valid=0, ptr=grant_idx+1 (2-bit wrap, 3->0), go RELEASE.
  - Otherwise stay in GRANT, hold_cnt+1 (timeout build only).
- State RELEASE:
  - One dead cycle with grant=0. This guarantees a turnaround gap on the shared resource.
  - Unconditionally return to IDLE. Arbitration resumes the following edge, so the minimum gap between two grants is 2 cycles.
- Requests from other requesters during GRANT are ignored; they are not latched and must be held.
- Lower bits of req that drop or rise in IDLE are simply re-sampled each edge. No request memory is kept.
- enable=0 while in IDLE: no grant, ptr unchanged.
- ptr wrap: the winner is 3 -> ptr=0. A single requester that keeps re-requesting is regranted after the 2-cycle gap.
- Reset mid-GRANT: grant drops asynchronously to 0; after release, arbitration restarts from ptr=0.
- grant_idx keeps the last winner value after release. Consumers qualify it with grant_valid.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - hold_cnt counts GRANT cycles.
  - At an edge in GRANT where hold_cnt==MAX_HOLD-1 and the requester is still active, force release: grant_valid=0, ptr=grant_idx+1, preempt=1 for exactly that next cycle, go RELEASE.
  - The holder therefore sees grant for exactly MAX_HOLD cycles.
  - A normal release on the same edge as the timeout takes the normal path: preempt=0.
- Undefined:
  - No counter is built; preempt is tied 0.
  - Grants last until req drops or enable=0.

Test Plan:
- Reset then release with req=4'b0000, enable=1 for 5 cycles -> grant=0000, grant_idx=00, grant_valid=0, preempt=0 throughout.
- req=4'b1010 held, enable=1 -> first grant=0010 (idx 1) one cycle after sampling.
  - Drop req[1] -> RELEASE, then grant=1000 (idx 3).
  - Drop req[3] -> ptr=0.
- req=4'b1111, each requester drops its req after 2 grant cycles and re-raises it in RELEASE -> grant order 0001, 0010, 0100, 1000, 0001, with one zero RELEASE cycle plus one IDLE cycle between grants.
- While grant=0100, pull enable=0 -> next edge grant=0000, state RELEASE, ptr=3.
  - Keep enable=0 with req=4'b1111 -> grant stays 0000 until enable=1; then grant=1000.
- Assert reset=0 asynchronously mid-GRANT (between clock edges) -> grant=0000 and grant_valid=0 immediately.
  - After release with req=4'b1111 -> grant=0001.
- ARB_TIMEOUT_EN, MAX_HOLD=3, req=4'b0001 held -> grant=0001 for exactly 3 cycles, then preempt=1 and grant=0000 for 1 cycle, then grant=0001 again after IDLE. Without the macro -> grant stays 0001 indefinitely and preempt=0.

Source files
------------

// File: rtl/rr_decode_arbiter_if.sv
// rtl/rr_decode_arbiter_if.sv - request/grant bundle between the requesters and the round-robin arbiter.
interface rr_decode_arbiter_if;
   logic       enable;
   logic [3:0] req;
   logic [3:0] grant;
   logic [1:0] grant_idx;
   logic       grant_valid;
   logic       preempt;

   modport master (
      output enable, req,
      input  grant, grant_idx, grant_valid, preempt
   );

   modport slave (
      input  enable, req,
      output grant, grant_idx, grant_valid, preempt
   );
endinterface

// File: rtl/rr_decode_arbiter.sv
// rtl/rr_decode_arbiter.sv - 4-way round-robin arbiter with encoded and one-hot grants.
// Define ARB_TIMEOUT_EN to build the hold counter that preempts a holder after MAX_HOLD cycles.
module rr_decode_arbiter #(
   parameter int MAX_HOLD = 8,
   parameter int CNT_W    = 4
) (
   input logic            clk,
   input logic            reset,
   rr_decode_arbiter_if.slave bus
);

   typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

   if (MAX_HOLD < 1 || MAX_HOLD > (1 << CNT_W)) begin : g_bad_max_hold
      $error("MAX_HOLD out of range for CNT_W");
   end

   state_t     state, state_nxt;
   logic [1:0] ptr, ptr_nxt;
   logic [1:0] idx, idx_nxt;
   logic       valid, valid_nxt;
   logic [3:0] grant_q, grant_nxt;
   logic [1:0] winner, cand;
   logic       found;

`ifdef ARB_TIMEOUT_EN
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);
   logic [CNT_W-1:0] hold_cnt, hold_nxt;
   logic             pre, pre_nxt;
`endif

   // First requester found scanning upward from the rotating pointer.
   always_comb begin
      winner = ptr;
      cand   = ptr;
      found  = 1'b0;
      for (int i = 0; i < 4; i++) begin
         cand = ptr + 2'(i);
         if (!found && bus.req[cand]) begin
            winner = cand;
            found  = 1'b1;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      ptr_nxt   = ptr;
      idx_nxt   = idx;
      valid_nxt = valid;
`ifdef ARB_TIMEOUT_EN
      hold_nxt  = hold_cnt;
      pre_nxt   = 1'b0;
`endif
      case (state)
         IDLE: begin
            valid_nxt = 1'b0;
            if (bus.enable && found) begin
               idx_nxt   = winner;
               valid_nxt = 1'b1;
               state_nxt = GRANT;
`ifdef ARB_TIMEOUT_EN
               hold_nxt  = '0;
`endif
            end
         end
         GRANT: begin
            if (!bus.enable || !bus.req[idx]) begin
               valid_nxt = 1'b0;
               ptr_nxt   = idx + 2'd1;
               state_nxt = RELEASE;
            end
`ifdef ARB_TIMEOUT_EN
            else if (hold_cnt == HOLD_LAST) begin
               valid_nxt = 1'b0;
               ptr_nxt   = idx + 2'd1;
               pre_nxt   = 1'b1;
               state_nxt = RELEASE;
            end else begin
               hold_nxt = hold_cnt + 1'b1;
            end
`endif
         end
         RELEASE: begin
            valid_nxt = 1'b0;
            state_nxt = IDLE;
         end
         default: begin
            valid_nxt = 1'b0;
            state_nxt = IDLE;
         end
      endcase
      grant_nxt = valid_nxt ? (4'b0001 << idx_nxt) : 4'b0000;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         ptr     <= 2'd0;
         idx     <= 2'd0;
         valid   <= 1'b0;
         grant_q <= 4'b0000;
      end else begin
         state   <= state_nxt;
         ptr     <= ptr_nxt;
         idx     <= idx_nxt;
         valid   <= valid_nxt;
         grant_q <= grant_nxt;
      end
   end

`ifdef ARB_TIMEOUT_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         hold_cnt <= '0;
         pre      <= 1'b0;
      end else begin
         hold_cnt <= hold_nxt;
         pre      <= pre_nxt;
      end
   end
   assign bus.preempt = pre;
`else
   assign bus.preempt = 1'b0;
`endif

   assign bus.grant       = grant_q;
   assign bus.grant_idx   = idx;
   assign bus.grant_valid = valid;

endmodule

// File: tb/tb_rr_decode_arbiter.sv
// tb/tb_rr_decode_arbiter.sv - directed-vector bench for rr_decode_arbiter.
module tb_rr_decode_arbiter;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   failures = 0;
   logic [3:0] exp_g;
   logic [1:0] exp_i;

   always #5 clk = ~clk;

   rr_decode_arbiter_if bus();

   rr_decode_arbiter #(.MAX_HOLD(3), .CNT_W(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %b expected %b", tag, obs[7:0], exp[7:0]);
      end
   endtask

   // Packed as {grant, grant_idx, grant_valid, preempt}.
   task automatic expect_out(input string tag, input logic [3:0] g, input logic [1:0] i,
                             input logic v, input logic p);
      check(tag, {24'b0, bus.grant, bus.grant_idx, bus.grant_valid, bus.preempt},
                 {24'b0, g, i, v, p});
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      reset      = 1'b0;
      bus.enable = 1'b1;
      bus.req    = 4'b0000;
      #12;
      expect_out("reset_async", 4'b0000, 2'd0, 1'b0, 1'b0);
      step(2);
      expect_out("reset_held", 4'b0000, 2'd0, 1'b0, 1'b0);
      @(negedge clk);
      reset = 1'b1;

      for (int c = 0; c < 5; c++) begin
         step(1);
         expect_out("idle_no_req", 4'b0000, 2'd0, 1'b0, 1'b0);
      end

      bus.req = 4'b1010;
      step(1);
      expect_out("first_grant_idx1", 4'b0010, 2'd1, 1'b1, 1'b0);
      step(1);
      expect_out("hold_idx1", 4'b0010, 2'd1, 1'b1, 1'b0);
      bus.req = 4'b1000;
      step(1);
      expect_out("release_idx1", 4'b0000, 2'd1, 1'b0, 1'b0);
      step(1);
      expect_out("idle_after_idx1", 4'b0000, 2'd1, 1'b0, 1'b0);
      step(1);
      expect_out("grant_idx3", 4'b1000, 2'd3, 1'b1, 1'b0);
      bus.req = 4'b0000;
      step(1);
      expect_out("release_idx3", 4'b0000, 2'd3, 1'b0, 1'b0);
      step(1);
      expect_out("idle_after_idx3", 4'b0000, 2'd3, 1'b0, 1'b0);

      bus.req = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         exp_i = 2'(k % 4);
         exp_g = 4'b0001 << exp_i;
         step(1);
         expect_out("rr_grant", exp_g, exp_i, 1'b1, 1'b0);
         step(1);
         expect_out("rr_hold", exp_g, exp_i, 1'b1, 1'b0);
         bus.req = 4'b1111 & ~exp_g;
         step(1);
         expect_out("rr_release", 4'b0000, exp_i, 1'b0, 1'b0);
         bus.req = 4'b1111;
         step(1);
         expect_out("rr_idle", 4'b0000, exp_i, 1'b0, 1'b0);
      end

      step(1);
      expect_out("pre_en_grant1", 4'b0010, 2'd1, 1'b1, 1'b0);
      bus.req = 4'b1101;
      step(1);
      expect_out("pre_en_release1", 4'b0000, 2'd1, 1'b0, 1'b0);
      bus.req = 4'b1111;
      step(2);
      expect_out("pre_en_grant2", 4'b0100, 2'd2, 1'b1, 1'b0);
      bus.enable = 1'b0;
      step(1);
      expect_out("enable_drop", 4'b0000, 2'd2, 1'b0, 1'b0);
      for (int c = 0; c < 4; c++) begin
         step(1);
         expect_out("enable_low_idle", 4'b0000, 2'd2, 1'b0, 1'b0);
      end
      bus.enable = 1'b1;
      step(1);
      expect_out("enable_back_grant3", 4'b1000, 2'd3, 1'b1, 1'b0);

      #3;
      reset = 1'b0;
      #1;
      expect_out("reset_mid_grant", 4'b0000, 2'd0, 1'b0, 1'b0);
      @(negedge clk);
      reset = 1'b1;
      step(1);
      expect_out("after_reset_grant0", 4'b0001, 2'd0, 1'b1, 1'b0);

      bus.req = 4'b0001;
`ifdef ARB_TIMEOUT_EN
      step(1);
      expect_out("to_hold2", 4'b0001, 2'd0, 1'b1, 1'b0);
      step(1);
      expect_out("to_hold3", 4'b0001, 2'd0, 1'b1, 1'b0);
      step(1);
      expect_out("to_preempt", 4'b0000, 2'd0, 1'b0, 1'b1);
      step(1);
      expect_out("to_idle", 4'b0000, 2'd0, 1'b0, 1'b0);
      step(1);
      expect_out("to_regrant", 4'b0001, 2'd0, 1'b1, 1'b0);
`else
      for (int c = 0; c < 10; c++) begin
         step(1);
         expect_out("no_timeout_hold", 4'b0001, 2'd0, 1'b1, 1'b0);
      end
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
